// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared pointer-code helpers and width rules for the multi-channel FIFO memory
package fifo_pkg;

    // Pointers narrower than this are zero-extended into the helpers and truncated afterwards.
    localparam int PTR_MAX_W = 32;

    // Channel index width: log2 of the channel count, never below one bit.
    function automatic int ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // Zero-extension does not disturb the Gray code of the low bits.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Leading zeros contribute nothing to the prefix XOR, so narrow pointers decode correctly.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - per-channel write pointer, full, almost-full and sticky overflow
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic                  inc,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
    input  logic                  ovf_clr,
    output logic [ADDR_WIDTH:0]   wbin,
    output logic [ADDR_WIDTH:0]   wgray,
    output logic                  full,
    output logic                  almost_full,
    output logic                  ovf,
    output logic                  accept
);

    localparam int PW       = ADDR_WIDTH + 1;
    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam int AF_CLAMP = (AF_MARGIN > DEPTH) ? DEPTH : AF_MARGIN;
    localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
    localparam logic [PW-1:0] AF_V    = PW'(AF_CLAMP);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic          ovf_q, ovf_d;

    logic [PW-1:0]        rbin;
    logic [PW-1:0]        used;
    logic [PW-1:0]        free;
    logic                 full_c;
    logic [PTR_MAX_W-1:0] rg_ext;
    logic [PTR_MAX_W-1:0] rbin_ext;
    logic [PTR_MAX_W-1:0] wgray_ext;

    // Full compares Gray codes directly; occupancy decodes the read pointer back to binary.
    always_comb begin
        rg_ext   = {{(PTR_MAX_W - PW){1'b0}}, rptr_gray_sync};
        rbin_ext = gray2bin(rg_ext);
        rbin     = rbin_ext[PW-1:0];
        full_c   = (wgray_q == {~rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                                rptr_gray_sync[ADDR_WIDTH-2:0]});
        used     = wbin_q - rbin;
        free     = DEPTH_V - used;
    end

    // Advance both pointer codes on an accepted write; Gray tracks binary+1 in the same edge.
    always_comb begin
        accept    = inc && !full_c;
        wbin_d    = accept ? (wbin_q + PW'(1)) : wbin_q;
        wgray_ext = bin2gray({{(PTR_MAX_W - PW){1'b0}}, wbin_d});
        wgray_d   = wgray_ext[PW-1:0];
    end

    // Overflow is sticky; a rejected write beats a clear arriving in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (inc && full_c) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Pointer and flag registers, cleared asynchronously with the write domain.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wbin        = wbin_q;
    assign wgray       = wgray_q;
    assign full        = full_c;
    assign almost_full = (free <= AF_V);
    assign ovf         = ovf_q;

endmodule

// File: rtl/fifo_memory_mc.sv
// rtl/fifo_memory_mc.sv - shared multi-channel FIFO storage with write control; FIFO_MEM_PARITY_EN adds per-entry parity
module fifo_memory_mc
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CH         = 2,
    parameter int AF_MARGIN  = 2,
    localparam int CH_W      = ch_width(CH)
) (
    input  logic                          w_clk,
    input  logic                          w_rst_n,
    input  logic                          w_inc,
    input  logic [CH_W-1:0]               w_ch,
    input  logic [DATA_WIDTH-1:0]         w_data,
    input  logic [CH*(ADDR_WIDTH+1)-1:0]  rptr_gray_sync,
    input  logic [CH-1:0]                 w_ovf_clr,
    output logic [CH*(ADDR_WIDTH+1)-1:0]  w_ptr_gray,
    output logic [CH-1:0]                 w_full,
    output logic [CH-1:0]                 w_almost_full,
    output logic [CH-1:0]                 w_ovf,
    input  logic [CH_W-1:0]               rd_ch,
    input  logic [ADDR_WIDTH-1:0]         rd_address,
`ifdef FIFO_MEM_PARITY_EN
    output logic                          rd_parity_err,
`endif
    output logic [DATA_WIDTH-1:0]         rd_data
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int IDX_W = CH_W + ADDR_WIDTH;

    logic [CH-1:0]         inc_vec;
    logic [CH-1:0]         accept_vec;
    logic [ADDR_WIDTH:0]   wbin [CH];
    logic                  wr_ch_valid;
    logic                  rd_ch_valid;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;

    // Storage is deliberately not reset so it can map onto a RAM or latch array.
    logic [DATA_WIDTH-1:0] mem [CH*DEPTH];

    // Out-of-range channel indices only exist when CH is not a power of two.
    generate
        if (CH == (1 << CH_W)) begin : g_ch_full_range
            assign wr_ch_valid = 1'b1;
            assign rd_ch_valid = 1'b1;
        end else begin : g_ch_partial_range
            assign wr_ch_valid = (w_ch < CH_W'(CH));
            assign rd_ch_valid = (rd_ch < CH_W'(CH));
        end
    endgenerate

    // One-hot write request per channel.
    always_comb begin
        inc_vec = '0;
        for (int c = 0; c < CH; c++) begin
            inc_vec[c] = w_inc && wr_ch_valid && (w_ch == CH_W'(c));
        end
    end

    generate
        for (genvar c = 0; c < CH; c++) begin : g_ch
            fifo_wptr_full #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .AF_MARGIN  (AF_MARGIN)
            ) u_wptr (
                .w_clk          (w_clk),
                .w_rst_n        (w_rst_n),
                .inc            (inc_vec[c]),
                .rptr_gray_sync (rptr_gray_sync[c*PW +: PW]),
                .ovf_clr        (w_ovf_clr[c]),
                .wbin           (wbin[c]),
                .wgray          (w_ptr_gray[c*PW +: PW]),
                .full           (w_full[c]),
                .almost_full    (w_almost_full[c]),
                .ovf            (w_ovf[c]),
                .accept         (accept_vec[c])
            );
        end
    endgenerate

    // Pick the target channel's write address and acceptance.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        for (int c = 0; c < CH; c++) begin
            if (inc_vec[c]) begin
                wr_en   = accept_vec[c];
                wr_addr = wbin[c][ADDR_WIDTH-1:0];
            end
        end
    end

    assign wr_idx = {w_ch, wr_addr};
    assign rd_idx = {rd_ch, rd_address};

    // Shared storage array, written only on an accepted write.
    always_ff @(posedge w_clk) begin
        if (wr_en) begin
            mem[wr_idx] <= w_data;
        end
    end

    assign rd_data = rd_ch_valid ? mem[rd_idx] : '0;

`ifdef FIFO_MEM_PARITY_EN
    logic [CH*DEPTH-1:0] par_q, par_d;

    // Capture even parity of the incoming word alongside the data.
    always_comb begin
        par_d = par_q;
        if (wr_en) begin
            par_d[wr_idx] = ^w_data;
        end
    end

    // Parity bits are small enough to reset, unlike the data array.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            par_q <= '0;
        end else begin
            par_q <= par_d;
        end
    end

    assign rd_parity_err = rd_ch_valid && ((^mem[rd_idx]) ^ par_q[rd_idx]);
`endif

endmodule

// File: tb/tb_fifo_memory_mc.sv
// tb/tb_fifo_memory_mc.sv - directed self-checking bench for fifo_memory_mc
module tb_fifo_memory_mc;

    logic        w_clk;
    logic        w_rst_n;
    logic        w_inc;
    logic [0:0]  w_ch;
    logic [7:0]  w_data;
    logic [9:0]  rptr_gray_sync;
    logic [1:0]  w_ovf_clr;
    logic [9:0]  w_ptr_gray;
    logic [1:0]  w_full;
    logic [1:0]  w_almost_full;
    logic [1:0]  w_ovf;
    logic [0:0]  rd_ch;
    logic [3:0]  rd_address;
    logic [7:0]  rd_data;
`ifdef FIFO_MEM_PARITY_EN
    logic        rd_parity_err;
`endif

    int checks   = 0;
    int failures = 0;

    fifo_memory_mc dut (
        .w_clk          (w_clk),
        .w_rst_n        (w_rst_n),
        .w_inc          (w_inc),
        .w_ch           (w_ch),
        .w_data         (w_data),
        .rptr_gray_sync (rptr_gray_sync),
        .w_ovf_clr      (w_ovf_clr),
        .w_ptr_gray     (w_ptr_gray),
        .w_full         (w_full),
        .w_almost_full  (w_almost_full),
        .w_ovf          (w_ovf),
        .rd_ch          (rd_ch),
        .rd_address     (rd_address),
`ifdef FIFO_MEM_PARITY_EN
        .rd_parity_err  (rd_parity_err),
`endif
        .rd_data        (rd_data)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] gray5(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic do_write(input logic ch, input logic [7:0] d, input logic [1:0] clr);
        w_ch      = ch;
        w_data    = d;
        w_inc     = 1'b1;
        w_ovf_clr = clr;
        @(posedge w_clk);
        #1;
        w_inc     = 1'b0;
        w_ovf_clr = 2'b00;
    endtask

    task automatic check_read(input string tag, input logic ch, input int addr, input logic [7:0] exp);
        rd_ch      = ch;
        rd_address = 4'(addr);
        @(negedge w_clk);
        check(tag, {24'h0, rd_data}, {24'h0, exp});
    endtask

    initial begin
        w_rst_n        = 1'b0;
        w_inc          = 1'b0;
        w_ch           = 1'b0;
        w_data         = 8'h00;
        rptr_gray_sync = 10'h000;
        w_ovf_clr      = 2'b00;
        rd_ch          = 1'b0;
        rd_address     = 4'h0;
        repeat (2) @(posedge w_clk);
        #1;
        check("rst_ptr_gray", {22'h0, w_ptr_gray}, 32'h0);
        check("rst_full", {30'h0, w_full}, 32'h0);
        check("rst_af", {30'h0, w_almost_full}, 32'h0);
        check("rst_ovf", {30'h0, w_ovf}, 32'h0);
        @(negedge w_clk);
        w_rst_n = 1'b1;
        @(posedge w_clk);
        #1;

        // Fill channel 0 with 0x10..0x1F
        for (int i = 0; i < 16; i++) begin
            do_write(1'b0, 8'(8'h10 + i), 2'b00);
            if (i == 12) check("ch0_af_after13", {31'h0, w_almost_full[0]}, 32'h0);
            if (i == 13) check("ch0_af_after14", {31'h0, w_almost_full[0]}, 32'h1);
            if (i == 14) check("ch0_full_after15", {31'h0, w_full[0]}, 32'h0);
        end
        check("ch0_full_after16", {30'h0, w_full}, 32'h1);
        check("ch0_ptr_after16", {22'h0, w_ptr_gray}, 32'h018);
        for (int i = 0; i < 16; i++) begin
            check_read("ch0_fill_read", 1'b0, i, 8'(8'h10 + i));
        end

        // Overflow on a full channel
        do_write(1'b0, 8'hAA, 2'b00);
        check("ovf_set", {30'h0, w_ovf}, 32'h1);
        check("ovf_ptr_hold", {22'h0, w_ptr_gray}, 32'h018);
        check_read("ovf_mem_hold0", 1'b0, 0, 8'h10);
        do_write(1'b0, 8'hBB, 2'b01);
        check("ovf_set_wins", {30'h0, w_ovf}, 32'h1);
        w_ovf_clr = 2'b01;
        @(posedge w_clk);
        #1;
        w_ovf_clr = 2'b00;
        check("ovf_clear", {30'h0, w_ovf}, 32'h0);

        // Channel 1 almost-full
        for (int i = 0; i < 14; i++) begin
            do_write(1'b1, 8'(8'h20 + i), 2'b00);
            if (i == 12) check("ch1_af_after13", {31'h0, w_almost_full[1]}, 32'h0);
        end
        check("ch1_af_after14", {31'h0, w_almost_full[1]}, 32'h1);
        check("ch1_full_after14", {31'h0, w_full[1]}, 32'h0);
        check("ch1_ptr_after14", {27'h0, w_ptr_gray[9:5]}, {27'h0, gray5(14)});
        check("ch0_full_indep", {31'h0, w_full[0]}, 32'h1);
        check("ch1_ovf_clear", {31'h0, w_ovf[1]}, 32'h0);

        // Wrap channel 0
        rptr_gray_sync = {5'b00000, 5'b11000};
        #1;
        check("wrap_empty_full", {31'h0, w_full[0]}, 32'h0);
        check("wrap_empty_af", {31'h0, w_almost_full[0]}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            do_write(1'b0, 8'(8'h30 + i), 2'b00);
            if (i == 14) begin
                check("wrap_full_after15", {31'h0, w_full[0]}, 32'h0);
                check("wrap_ptr_after15", {27'h0, w_ptr_gray[4:0]}, 32'h10);
            end
        end
        check("wrap_ptr_after16", {27'h0, w_ptr_gray[4:0]}, 32'h00);
        check("wrap_full_after16", {31'h0, w_full[0]}, 32'h1);
        check_read("wrap_read0", 1'b0, 0, 8'h30);
        check_read("wrap_read15", 1'b0, 15, 8'h3F);
        rptr_gray_sync = {5'b00000, 5'b00000};
        #1;
        check("wrap_rptr0_full", {31'h0, w_full[0]}, 32'h0);

        // Interleaved writes with identical data
        rptr_gray_sync = {gray5(14), 5'b00000};
        #1;
        check("ilv_ch1_af_drained", {31'h0, w_almost_full[1]}, 32'h0);
        do_write(1'b0, 8'h55, 2'b00);
        do_write(1'b1, 8'h55, 2'b00);
        do_write(1'b0, 8'h66, 2'b00);
        do_write(1'b1, 8'h66, 2'b00);
        check("ilv_ptrs", {22'h0, w_ptr_gray}, 32'h303);
        check("ilv_full", {30'h0, w_full}, 32'h0);
        check_read("ilv_ch0_a0", 1'b0, 0, 8'h55);
        check_read("ilv_ch0_a1", 1'b0, 1, 8'h66);
        check_read("ilv_ch0_a2", 1'b0, 2, 8'h32);
        check_read("ilv_ch1_a14", 1'b1, 14, 8'h55);
        check_read("ilv_ch1_a15", 1'b1, 15, 8'h66);
        check_read("ilv_ch1_a0", 1'b1, 0, 8'h20);

`ifdef FIFO_MEM_PARITY_EN
        do_write(1'b0, 8'h07, 2'b00);
        check_read("par_data", 1'b0, 2, 8'h07);
        check("par_clean", {31'h0, rd_parity_err}, 32'h0);
        dut.mem[2] = dut.mem[2] ^ 8'h01;
        #1;
        check("par_flipped", {31'h0, rd_parity_err}, 32'h1);
        rd_address = 4'd1;
        #1;
        check("par_other_clean", {31'h0, rd_parity_err}, 32'h0);
`endif

        // Asynchronous reset mid-operation
        rptr_gray_sync = 10'h000;
        @(negedge w_clk);
        #2;
        w_rst_n = 1'b0;
        #1;
        check("async_rst_ptr", {22'h0, w_ptr_gray}, 32'h0);
        check("async_rst_full", {30'h0, w_full}, 32'h0);
        check("async_rst_af", {30'h0, w_almost_full}, 32'h0);
        w_rst_n = 1'b1;
        repeat (2) @(posedge w_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
